video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Pixel-clock raster timing generator for the 1280x720@60 HDMI output path. Advances a horizontal/vertical pixel counter pair and derives sync, active-draw, new-frame and frame-count signals from it. Sits at the head of the video pipeline; its `hcount_out`/`vcount_out` feed the downstream combinational pixel generators (staff background, note sprites), and its syncs and active-draw are pipelined alongside their colour outputs to the TMDS encoder.

## Interface
- `ACTIVE_H_PIXELS`, 1280: visible pixels per line
- `H_FRONT_PORCH`, 110: pixels after active region before hsync
- `H_SYNC_WIDTH`, 40: hsync pulse width, pixels
- `H_BACK_PORCH`, 220: pixels after hsync before next line
- `ACTIVE_LINES`, 720: visible lines per frame
- `V_FRONT_PORCH`, 5: lines after active region before vsync
- `V_SYNC_WIDTH`, 5: vsync pulse width, lines
- `V_BACK_PORCH`, 20: lines after vsync before next frame
- `FPS`, 60: frame counter modulus
- Derived: H_TOTAL = sum of the horizontal parameters (1650); V_TOTAL = sum of the vertical parameters (750).

- `clk_pixel_in`  in  1  pixel clock (74.25 MHz). This is the block's only clock.
- `rst_in`  in  1  reset. Synchronous and active-high.
- `hcount_out`  out  11  current pixel column, 0..H_TOTAL-1
- `vcount_out`  out  10  current line, 0..V_TOTAL-1
- `hs_out`  out  1  horizontal sync
- `vs_out`  out  1  vertical sync
- `ad_out`  out  1  active draw: high when hcount_out < ACTIVE_H_PIXELS and vcount_out < ACTIVE_LINES
- `nf_out`  out  1  new-frame strobe, one cycle wide
- `fc_out`  out  6  frame counter, 0..FPS-1

## Operation
- All outputs are registered. On every edge where `rst_in` is low, the block computes the next raster position and loads all outputs from that position in the same edge, so the outputs are mutually coherent.
- Horizontal counting: `hcount_out` increments by 1 each cycle. When `hcount_out` = H_TOTAL-1, the next value is 0 and `vcount_out` increments.
- Vertical counting: when `vcount_out` = V_TOTAL-1 at the end of a line, `vcount_out` wraps to 0.
- `hs_out` is high (active) when hcount is in [ACTIVE_H_PIXELS+H_FRONT_PORCH, ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH-1], i.e. [1390, 1429].
- `vs_out` is high (active) for the whole of lines [ACTIVE_LINES+V_FRONT_PORCH, ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH-1], i.e. [725, 729]. It is independent of hcount.
- `nf_out` is high only at position (hcount=0, vcount=ACTIVE_LINES), the first pixel after the last active line.
- `fc_out` increments in the same edge that asserts `nf_out`. It wraps from FPS-1 to 0.
- Width rules: comparisons are unsigned. Parameters must satisfy H_TOTAL ≤ 2048, V_TOTAL ≤ 1024 and FPS ≤ 64; this is checked by an elaboration-time assertion.

## Timing
- Reset values (while `rst_in` is high):
  - `hcount_out` = H_TOTAL-1 (1649) and `vcount_out` = V_TOTAL-1 (749), i.e. the last pixel of a frame.
  - `hs_out`, `vs_out`, `ad_out`, `nf_out` = 0.
  - `fc_out` = 0.
- First edge after `rst_in` falls: (0,0), `ad_out`=1, `nf_out`=0. Frame 0 therefore starts cleanly, with no partial frame.
- Reset asserted mid-frame: the next edge forces the reset state regardless of the current position. No strobe is emitted, and `fc_out` is not incremented by the reset itself.
- The block has 0 cycles of latency between `hcount_out`/`vcount_out` and the associated `hs_out`/`vs_out`/`ad_out`. Downstream logic adds any matching delay it needs.
- Line period = H_TOTAL cycles. Frame period = H_TOTAL*V_TOTAL = 1,237,500 cycles. `nf_out` asserts exactly once per frame period.
- Simultaneous events: at (0, ACTIVE_LINES), the line wrap, `nf_out` assertion and `fc_out` increment all occur in the same edge.

## Configuration
- Macro: `VIDEO_TIMING_SYNC_INVERT_EN`.
- Undefined (default): `hs_out`/`vs_out` are active-high per 720p CEA timing, idle 0, reset value 0.
- Defined: `hs_out`/`vs_out` are active-low, idle 1, reset value 1. The assertion windows are identical to the default.
- The macro has no effect on any other output.

## Test plan
- Hold `rst_in` for 3 cycles, then release -> while in reset: hcount=1649, vcount=749, all flags 0, fc=0; first edge after release: (0,0), ad=1.
- Run one line -> ad high for cycles 0..1279; hs high for exactly 40 cycles, starting at hcount=1390; at hcount=1649 the next edge gives hcount=0, vcount=1.
- Run to end of active region -> at (1279,719) ad=1; at (0,720) nf=1 for exactly one cycle, fc=1, ad=0.
- Run full frames -> vs high for exactly 5*1650 cycles on lines 725..729; nf pulses are spaced exactly 1,237,500 cycles apart; after 60 frames, fc wraps 59->0.
- Assert `rst_in` at (700,400), then release -> the edge after assertion gives (1649,749) with fc=0; the edge after release gives (0,0).
- Build with `VIDEO_TIMING_SYNC_INVERT_EN` -> hs/vs = 1 in reset and idle, 0 in the same windows as the default build; all other outputs are bit-identical to the default build.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, active-draw, new-frame and frame count.
// Optional macro VIDEO_TIMING_SYNC_INVERT_EN makes hs_out/vs_out active-low.
module video_timing_gen #(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned H_FRONT_PORCH   = 110,
  parameter int unsigned H_SYNC_WIDTH    = 40,
  parameter int unsigned H_BACK_PORCH    = 220,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned V_FRONT_PORCH   = 5,
  parameter int unsigned V_SYNC_WIDTH    = 5,
  parameter int unsigned V_BACK_PORCH    = 20,
  parameter int unsigned FPS             = 60
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int unsigned H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACTIVE = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] HS_FIRST = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [10:0] HS_LAST  = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACTIVE = 10'(ACTIVE_LINES);
  localparam logic [9:0]  VS_FIRST = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [9:0]  VS_LAST  = 10'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

`ifdef VIDEO_TIMING_SYNC_INVERT_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || FPS > 64 || FPS == 0) begin : g_param_check
    $error("video_timing_gen: raster parameters exceed counter widths");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ad_q, ad_d;
  logic        nf_q, nf_d;
  logic [5:0]  fc_q, fc_d;

  // Every flag is decoded from the *next* position so it lands in the same edge as the counters.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end

    hs_d = SYNC_IDLE;
    if (hcount_d >= HS_FIRST && hcount_d <= HS_LAST) hs_d = ~SYNC_IDLE;
    vs_d = SYNC_IDLE;
    if (vcount_d >= VS_FIRST && vcount_d <= VS_LAST) vs_d = ~SYNC_IDLE;

    ad_d = (hcount_d < H_ACTIVE) && (vcount_d < V_ACTIVE);
    nf_d = (hcount_d == 11'd0) && (vcount_d == V_ACTIVE);

    fc_d = fc_q;
    if (nf_d) fc_d = (fc_q == FC_LAST) ? 6'd0 : fc_q + 6'd1;
  end

  // Reset parks on the last pixel of a frame so the first free-running edge lands on (0,0).
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hs_q     <= SYNC_IDLE;
      vs_q     <= SYNC_IDLE;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
      fc_q     <= 6'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
      fc_q     <= fc_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full-size 720p instance for reset and line timing, and a
// shrunken-raster instance so whole frames, nf spacing and fc wrap fit in a short run.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int S_AH = 16, S_HFP = 3, S_HSW = 4, S_HBP = 5;
  localparam int S_AL = 10, S_VFP = 2, S_VSW = 3, S_VBP = 4, S_FPS = 4;
  localparam int S_HT = S_AH + S_HFP + S_HSW + S_HBP;   // 28
  localparam int S_VT = S_AL + S_VFP + S_VSW + S_VBP;   // 19
  localparam int S_FRAME = S_HT * S_VT;                 // 532

`ifdef VIDEO_TIMING_SYNC_INVERT_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } vid_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s;
  logic [10:0] hc_d, hc_s;
  logic [9:0]  vc_d, vc_s;
  logic        hs_d, hs_s, vs_d, vs_s, ad_d, ad_s, nf_d, nf_s;
  logic [5:0]  fc_d, fc_s;
  vid_t        obs_d, obs_s;

  assign obs_d = {hc_d, vc_d, hs_d, vs_d, ad_d, nf_d, fc_d};
  assign obs_s = {hc_s, vc_s, hs_s, vs_s, ad_s, nf_s, fc_s};

  video_timing_gen u_dut_720p (
    .clk_pixel_in(clk), .rst_in(rst_d),
    .hcount_out(hc_d), .vcount_out(vc_d), .hs_out(hs_d), .vs_out(vs_d),
    .ad_out(ad_d), .nf_out(nf_d), .fc_out(fc_d)
  );

  video_timing_gen #(
    .ACTIVE_H_PIXELS(S_AH), .H_FRONT_PORCH(S_HFP), .H_SYNC_WIDTH(S_HSW), .H_BACK_PORCH(S_HBP),
    .ACTIVE_LINES(S_AL), .V_FRONT_PORCH(S_VFP), .V_SYNC_WIDTH(S_VSW), .V_BACK_PORCH(S_VBP),
    .FPS(S_FPS)
  ) u_dut_small (
    .clk_pixel_in(clk), .rst_in(rst_s),
    .hcount_out(hc_s), .vcount_out(vc_s), .hs_out(hs_s), .vs_out(vs_s),
    .ad_out(ad_s), .nf_out(nf_s), .fc_out(fc_s)
  );

  int checks = 0;
  int failures = 0;
  int n_d = -1;
  int n_s = -1;
  vid_t q_d[$];
  vid_t q_s[$];

  // Reference: n is the number of free-running edges since reset released, minus one (-1 = in reset).
  function automatic vid_t model(input int n, input int ah, input int hfp, input int hsw, input int hbp,
                                 input int al, input int vfp, input int vsw, input int vbp, input int fps);
    vid_t e;
    int ht, vt, h, v;
    ht = ah + hfp + hsw + hbp;
    vt = al + vfp + vsw + vbp;
    if (n < 0) begin
      e.hc = 11'(ht - 1); e.vc = 10'(vt - 1);
      e.hs = SYNC_IDLE;   e.vs = SYNC_IDLE;
      e.ad = 1'b0; e.nf = 1'b0; e.fc = 6'd0;
    end else begin
      h = n % ht;
      v = (n / ht) % vt;
      e.hc = 11'(h); e.vc = 10'(v);
      e.hs = (h >= ah + hfp && h < ah + hfp + hsw) ? ~SYNC_IDLE : SYNC_IDLE;
      e.vs = (v >= al + vfp && v < al + vfp + vsw) ? ~SYNC_IDLE : SYNC_IDLE;
      e.ad = (h < ah) && (v < al);
      e.nf = (h == 0) && (v == al);
      e.fc = (n >= al * ht) ? 6'((((n - al * ht) / (ht * vt)) + 1) % fps) : 6'd0;
    end
    return e;
  endfunction

  // Advances one clock; the expected value for the selected DUT is queued before the edge.
  task automatic tick(input bit sel_s);
    if (rst_d) n_d = -1; else n_d++;
    if (rst_s) n_s = -1; else n_s++;
    if (sel_s) q_s.push_back(model(n_s, S_AH, S_HFP, S_HSW, S_HBP, S_AL, S_VFP, S_VSW, S_VBP, S_FPS));
    else       q_d.push_back(model(n_d, 1280, 110, 40, 220, 720, 5, 5, 20, 60));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vid_t want;
    rst_d = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      want = q_d.pop_front();
      checks++;
      if (obs_d !== want) begin
        failures++;
        $display("FAIL reset cyc=%0d got hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
                 i, obs_d.hc, obs_d.vc, obs_d.hs, obs_d.vs, obs_d.ad, obs_d.nf, obs_d.fc,
                 want.hc, want.vc, want.hs, want.vs, want.ad, want.nf, want.fc);
      end
    end
    rst_d = 1'b0;
    tick(1'b0);
    want = q_d.pop_front();
    checks++;
    if (obs_d !== want || obs_d.hc !== 11'd0 || obs_d.vc !== 10'd0 || obs_d.ad !== 1'b1) begin
      failures++;
      $display("FAIL first_pixel got hc=%0d vc=%0d ad=%b nf=%b want hc=0 vc=0 ad=1 nf=0",
               obs_d.hc, obs_d.vc, obs_d.ad, obs_d.nf);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_line();
    vid_t want;
    int hs_cnt = 0, ad_cnt = 0, hs_first = -1;
    for (int i = 0; i < 2 * 1650 + 10; i++) begin
      tick(1'b0);
      want = q_d.pop_front();
      checks++;
      if (obs_d !== want) begin
        failures++;
        $display("FAIL line n=%0d got hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
                 n_d, obs_d.hc, obs_d.vc, obs_d.hs, obs_d.vs, obs_d.ad, obs_d.nf, obs_d.fc,
                 want.hc, want.vc, want.hs, want.vs, want.ad, want.nf, want.fc);
      end
      if (obs_d.vc == 10'd1 && obs_d.hs == ~SYNC_IDLE) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(obs_d.hc);
      end
      if (obs_d.vc == 10'd1 && obs_d.ad) ad_cnt++;
    end
    checks++;
    if (hs_cnt != 40 || hs_first != 1390) begin
      failures++;
      $display("FAIL hs_window got len=%0d start=%0d want len=40 start=1390", hs_cnt, hs_first);
    end
    checks++;
    if (ad_cnt != 1280) begin
      failures++;
      $display("FAIL ad_window got len=%0d want len=1280", ad_cnt);
    end
    $display("test_line done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_frames();
    vid_t want;
    int last_nf = -1, nf_cnt = 0, vs_cnt = 0;
    bit wrapped = 1'b0;
    logic [5:0] prev_fc;
    rst_s = 1'b0;
    prev_fc = 6'd0;
    for (int i = 0; i < 2600; i++) begin
      tick(1'b1);
      want = q_s.pop_front();
      checks++;
      if (obs_s !== want) begin
        failures++;
        $display("FAIL frame n=%0d got hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
                 n_s, obs_s.hc, obs_s.vc, obs_s.hs, obs_s.vs, obs_s.ad, obs_s.nf, obs_s.fc,
                 want.hc, want.vc, want.hs, want.vs, want.ad, want.nf, want.fc);
      end
      if (obs_s.vs == ~SYNC_IDLE) vs_cnt++;
      if (obs_s.nf === 1'b1) begin
        nf_cnt++;
        if (last_nf >= 0) begin
          checks++;
          if (i - last_nf != S_FRAME || vs_cnt != S_VSW * S_HT) begin
            failures++;
            $display("FAIL nf_period got spacing=%0d vs_cycles=%0d want spacing=%0d vs_cycles=%0d",
                     i - last_nf, vs_cnt, S_FRAME, S_VSW * S_HT);
          end
        end
        last_nf = i;
        vs_cnt = 0;
      end
      if (prev_fc == 6'(S_FPS - 1) && obs_s.fc == 6'd0) wrapped = 1'b1;
      prev_fc = obs_s.fc;
    end
    checks++;
    if (nf_cnt != 5 || !wrapped) begin
      failures++;
      $display("FAIL fc_wrap got nf_pulses=%0d wrapped=%0d want nf_pulses=5 wrapped=1", nf_cnt, wrapped);
    end
    $display("test_frames done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_mid_reset();
    vid_t want;
    bit found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      tick(1'b1);
      want = q_s.pop_front();
      checks++;
      if (obs_s !== want) begin
        failures++;
        $display("FAIL pre_reset n=%0d got hc=%0d vc=%0d fc=%0d want hc=%0d vc=%0d fc=%0d",
                 n_s, obs_s.hc, obs_s.vc, obs_s.fc, want.hc, want.vc, want.fc);
      end
      if (obs_s.hc == 11'd5 && obs_s.vc == 10'd11 && obs_s.fc != 6'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reset_target got found=0 want found=1");
    end
    rst_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      want = q_s.pop_front();
      checks++;
      if (obs_s !== want) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got hc=%0d vc=%0d hs=%b vs=%b nf=%b fc=%0d want hc=%0d vc=%0d hs=%b vs=%b nf=%b fc=%0d",
                 i, obs_s.hc, obs_s.vc, obs_s.hs, obs_s.vs, obs_s.nf, obs_s.fc,
                 want.hc, want.vc, want.hs, want.vs, want.nf, want.fc);
      end
    end
    rst_s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b1);
      want = q_s.pop_front();
      checks++;
      if (obs_s !== want) begin
        failures++;
        $display("FAIL post_reset n=%0d got hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
                 n_s, obs_s.hc, obs_s.vc, obs_s.hs, obs_s.vs, obs_s.ad, obs_s.nf, obs_s.fc,
                 want.hc, want.vc, want.hs, want.vs, want.ad, want.nf, want.fc);
      end
    end
    $display("test_mid_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    test_reset();
    test_line();
    test_frames();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
